div5_serial_engine: RTL
=======================

Name: div5_serial_engine

Overview:
- Sequential divide-by-five datapath stage, sitting directly downstream of the Tiny Tapeout pin wrapper.
- Accepts a WIDTH-bit dividend over a valid/ready handshake and processes it MSB-first, one bit per cycle, using a 5-state remainder recurrence.
- Returns the quotient and remainder over a second valid/ready handshake.
- The top-level wrapper drives `in_dividend` from `ui_in` and maps results to `uo_out`/`uio_out`.

Parameters:
- WIDTH, 8, dividend and quotient width in bits; legal range 2..32.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset; the wrapper drives it as the inverse of `rst_n`.
- in_valid  input  1  dividend offered.
- in_ready  output  1  engine can accept a dividend.
- in_dividend  input  WIDTH  unsigned dividend.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_quotient  output  WIDTH  floor(dividend / 5).
- out_remainder  output  3  dividend mod 5, range 0..4.
- busy  output  1  high while in SHIFT or DONE.

Behaviour:
- State machine: IDLE, SHIFT, DONE.
- Reset values:
  - state = IDLE, so `in_ready` = 1, `out_valid` = 0, `busy` = 0.
  - `out_quotient` = 0, `out_remainder` = 0.
  - Internal shift register, remainder and bit counter = 0.
- IDLE:
  - `in_ready` = 1.
  - On an edge with `in_valid` = 1: load the shift register with `in_dividend`, set rem = 0, cnt = WIDTH-1, quotient accumulator = 0, go to SHIFT.
- SHIFT: on each edge,
  - b = shift register MSB.
  - t = 2*rem + b, range 0..9, 4 bits.
  - qbit = (t >= 5).
  - rem <= t - 5*qbit.
  - Quotient accumulator shifts left with qbit appended; shift register shifts left.
  - If cnt = 0: load `out_quotient` and `out_remainder` with the final values and go to DONE. Otherwise cnt decrements.
- Output registers change only on the SHIFT->DONE edge and on reset. Between those edges they hold their previous result.
- DONE:
  - `out_valid` = 1; `out_quotient` and `out_remainder` are stable.
  - On an edge with `out_ready` = 1: go to IDLE.
  - With `out_ready` held low, DONE is held indefinitely and the outputs do not change.
- Latency: with the input handshake at edge E, `out_valid` rises after edge E+WIDTH.
- Throughput: one operation per WIDTH+2 cycles when `out_ready` is tied high.
- `in_valid` is ignored while not in IDLE; `in_ready` = 0 there, so the dividend is not captured.
- If `out_ready` is already high on entry to DONE, the handshake completes on the first DONE edge.
- `in_ready` and `out_valid` are never high in the same cycle; there is no input/output overlap.
- Reset mid-operation, in SHIFT or DONE: on the next edge, return to IDLE with all registers at their reset values. The in-flight result is discarded and never presented.
- Arithmetic is unsigned only. Dividend 0 yields 0 r 0. All-ones dividends have no overflow, since quotient <= dividend.
- `in_ready` and `out_valid` are decoded directly from the state register, not registered separately.

Decomposition:
- Package `div5_pkg`:
  - state enum `div5_state_t` {IDLE, SHIFT, DONE}.
  - constant `DIVISOR` = 5.
  - constant `REM_W` = 3.
- One natural combinational sub-module, `div5_step`:
  - inputs: rem[2:0], b.
  - outputs: rem_next[2:0], qbit.
  - Instantiated once in the engine; unit-testable exhaustively (10 legal input points).
- The counter width is $clog2(WIDTH), derived locally.

Test Plan:
- WIDTH=8, `out_ready`=1; dividends 0, 7, 254, 255 -> (q, r) = (0, 0), (1, 2), (50, 4), (51, 0). Each `out_valid` rises exactly 8 cycles after its input handshake.
- Exhaustive WIDTH=8 sweep 0..255 with random `in_valid`/`out_ready` gaps -> every result matches the model (d/5, d%5). Outputs stay stable while `out_valid`=1 and `out_ready`=0.
- Backpressure: dividend 100, `out_ready` held 0 for 20 cycles -> `out_valid` stays 1 with 20 r 0. `in_ready` stays 0, and a second `in_valid` (dividend 9) during this time is not captured.
- Reset mid-SHIFT: assert `rst` 3 cycles after accepting 200 -> next cycle shows IDLE, `in_ready`=1, outputs 0. No `out_valid` pulse follows.
- Back-to-back: `in_valid` held high with dividends 13 then 14, `out_ready`=1 -> results 2 r 3 then 2 r 4. The second acceptance occurs the cycle after the first output handshake.
- WIDTH=16: dividends 65535 and 12345 -> 13107 r 0 and 2469 r 0; latency is 16 cycles.

Source files
------------

// File: rtl/div5_pkg.sv
// Shared types and constants for the serial divide-by-five engine.
// Imported by the step cell and the engine top.
package div5_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } div5_state_t;

  localparam int DIVISOR = 5;
  localparam int REM_W   = 3;

  typedef logic [REM_W-1:0] rem_t;
  typedef logic [REM_W:0]   tmp_t;

endpackage

// File: rtl/div5_step.sv
// One MSB-first restoring step of the mod-5 recurrence.
// Legal inputs: rem 0..4, any b; rem_next stays in 0..4.
module div5_step
  import div5_pkg::*;
(
  input  logic [REM_W-1:0] rem,
  input  logic             b,
  output logic [REM_W-1:0] rem_next,
  output logic             qbit
);

  tmp_t t;
  tmp_t diff;

  always_comb begin
    t        = {rem, b};
    qbit     = (t >= tmp_t'(DIVISOR));
    diff     = t - (qbit ? tmp_t'(DIVISOR)
                         : tmp_t'(0));
    rem_next = diff[REM_W-1:0];
  end

endmodule

// File: rtl/div5_serial_engine.sv
// Bit-serial unsigned divide-by-five stage with
// valid/ready handshakes on both the input and the result side.
module div5_serial_engine
  import div5_pkg::*;
#(
  parameter int WIDTH = 8
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_dividend,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [2:0]       out_remainder,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [CW-1:0]    cnt_t;

  div5_state_t state_q;
  div5_state_t state_d;

  word_t sreg_q;
  word_t sreg_d;
  word_t acc_q;
  word_t acc_d;
  word_t quo_q;
  word_t quo_d;

  rem_t  rem_q;
  rem_t  rem_d;
  rem_t  remo_q;
  rem_t  remo_d;

  cnt_t  cnt_q;
  cnt_t  cnt_d;

  rem_t  step_rem;
  logic  step_qbit;
  word_t acc_sh;

  div5_step u_step (
    .rem      (rem_q),
    .b        (sreg_q[WIDTH-1]),
    .rem_next (step_rem),
    .qbit     (step_qbit)
  );

  always_comb begin
    acc_sh = (acc_q << 1)
           | word_t'(step_qbit);
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sreg_d  = in_dividend;
          rem_d   = '0;
          acc_d   = '0;
          cnt_d   = cnt_t'(WIDTH - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sreg_d = sreg_q << 1;
        acc_d  = acc_sh;
        rem_d  = step_rem;
        if (cnt_q == '0) begin
          quo_d   = acc_sh;
          remo_d  = step_rem;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      remo_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
    end
  end

  // Handshake flags come straight from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): in_ready  = 1'b1;
      (state_q == DONE): begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: busy = 1'b1;
    endcase
  end

  assign out_quotient  = quo_q;
  assign out_remainder = remo_q;

  a_rem_range: assert property (
    @(posedge clk) disable iff (rst)
    (rem_q < rem_t'(DIVISOR)) &&
    (remo_q < rem_t'(DIVISOR))
  );

endmodule
